// File: rtl/mem_slot_arbiter.sv
// Four-slot RAM port scheduler: slots 0/2 serve the CPU, 1/3 serve video, idle slots fall to DMA.
// Define ARB_STATS_EN to add saturating per-owner grant counters with a synchronous clear.
module mem_slot_arbiter #(
    parameter int SLOT_LEN = 20,
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 8
) (
    input  logic              CLOCK_50,
    input  logic              reset_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic [DATA_W-1:0] vid_rdata,
    output logic              vid_ack,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        slot_idx
`ifdef ARB_STATS_EN
    ,
    input  logic              stats_clr,
    output logic [15:0]       cpu_grants,
    output logic [15:0]       vid_grants,
    output logic [15:0]       dma_grants,
    output logic [15:0]       idle_slots
`endif
);

    typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_VID, OWN_DMA} owner_e;

    localparam int CNT_W = $clog2(SLOT_LEN);
    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(SLOT_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_SAMPLE  = CNT_W'(SLOT_LEN - 2);
    localparam logic [CNT_W-1:0] CNT_ACC_END = CNT_W'(SLOT_LEN - 3);

    logic [CNT_W-1:0]  slot_cnt_q;
    logic [1:0]        slot_idx_q, slot_idx_d;
    owner_e            owner_q, owner_d;
    logic              owner_we_q, owner_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              mem_we_q;
    logic [DATA_W-1:0] cpu_rdata_q, vid_rdata_q, dma_rdata_q;
    logic              cpu_ack_q, vid_ack_q, dma_ack_q;
    logic              slot_end;

    assign slot_end   = (slot_cnt_q == CNT_LAST);
    assign slot_idx_d = slot_idx_q + 2'd1;

    // Arbitration for the slot about to start; only used at the edge entering c=0.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        owner_d     = OWN_NONE;
        owner_we_d  = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if (!slot_idx_d[0]) begin
            if (cpu_req)      owner_d = OWN_CPU;
            else if (dma_req) owner_d = OWN_DMA;
        end else begin
            if (vid_req)      owner_d = OWN_VID;
            else if (dma_req) owner_d = OWN_DMA;
        end
        case (owner_d)
            OWN_CPU: begin
                owner_we_d  = cpu_we;
                mem_addr_d  = cpu_addr;
                mem_wdata_d = cpu_wdata;
            end
            OWN_VID: mem_addr_d = vid_addr;
            OWN_DMA: begin
                owner_we_d  = dma_we;
                mem_addr_d  = dma_addr;
                mem_wdata_d = dma_wdata;
            end
            default: ;
        endcase
    end

    // Slot sequencer: ADDR (c=0), ACCESS (1..L-3), SAMPLE (L-2), ACK (L-1).
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: the rdata holding registers are reset too, so every output is defined out of reset.
            slot_cnt_q  <= CNT_LAST;
            slot_idx_q  <= 2'd3;
            owner_q     <= OWN_NONE;
            owner_we_q  <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            cpu_rdata_q <= '0;
            vid_rdata_q <= '0;
            dma_rdata_q <= '0;
            cpu_ack_q   <= 1'b0;
            vid_ack_q   <= 1'b0;
            dma_ack_q   <= 1'b0;
        end else begin
            cpu_ack_q <= 1'b0;
            vid_ack_q <= 1'b0;
            dma_ack_q <= 1'b0;
            if (slot_end) begin
                slot_cnt_q  <= '0;
                slot_idx_q  <= slot_idx_d;
                owner_q     <= owner_d;
                owner_we_q  <= owner_we_d;
                mem_addr_q  <= mem_addr_d;
                mem_wdata_q <= mem_wdata_d;
                mem_we_q    <= 1'b0;
            end else begin
                slot_cnt_q <= slot_cnt_q + CNT_W'(1);
                mem_we_q   <= owner_we_q && (slot_cnt_q < CNT_ACC_END);
                if (slot_cnt_q == CNT_SAMPLE) begin
                    case (owner_q)
                        OWN_CPU: begin
                            cpu_ack_q <= 1'b1;
                            if (!owner_we_q) cpu_rdata_q <= mem_rdata;
                        end
                        OWN_VID: begin
                            vid_ack_q   <= 1'b1;
                            vid_rdata_q <= mem_rdata;
                        end
                        OWN_DMA: begin
                            dma_ack_q <= 1'b1;
                            if (!owner_we_q) dma_rdata_q <= mem_rdata;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    assign slot_idx  = slot_idx_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_we    = mem_we_q;
    assign cpu_rdata = cpu_rdata_q;
    assign vid_rdata = vid_rdata_q;
    assign dma_rdata = dma_rdata_q;
    assign cpu_ack   = cpu_ack_q;
    assign vid_ack   = vid_ack_q;
    assign dma_ack   = dma_ack_q;

`ifdef ARB_STATS_EN
    logic [15:0] cpu_grants_q, vid_grants_q, dma_grants_q, idle_slots_q;

    // Clear has priority over a coincident slot-entry increment.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            cpu_grants_q <= '0;
            vid_grants_q <= '0;
            dma_grants_q <= '0;
            idle_slots_q <= '0;
        end else if (stats_clr) begin
            cpu_grants_q <= '0;
            vid_grants_q <= '0;
            dma_grants_q <= '0;
            idle_slots_q <= '0;
        end else if (slot_end) begin
            case (owner_d)
                OWN_CPU:  if (cpu_grants_q != 16'hFFFF) cpu_grants_q <= cpu_grants_q + 16'd1;
                OWN_VID:  if (vid_grants_q != 16'hFFFF) vid_grants_q <= vid_grants_q + 16'd1;
                OWN_DMA:  if (dma_grants_q != 16'hFFFF) dma_grants_q <= dma_grants_q + 16'd1;
                default:  if (idle_slots_q != 16'hFFFF) idle_slots_q <= idle_slots_q + 16'd1;
            endcase
        end
    end

    assign cpu_grants = cpu_grants_q;
    assign vid_grants = vid_grants_q;
    assign dma_grants = dma_grants_q;
    assign idle_slots = idle_slots_q;
`endif

endmodule

// File: tb/tb_mem_slot_arbiter.sv
// Self-checking bench for mem_slot_arbiter (SLOT_LEN=4): slot-position reference model,
// per-cycle compare, directed literal scenarios, then randomized traffic.
module tb_mem_slot_arbiter;

    localparam int L = 4;
    localparam int OWN_NONE = 0, OWN_CPU = 1, OWN_VID = 2, OWN_DMA = 3;

    logic        CLOCK_50 = 1'b0;
    logic        reset_n;
    logic        cpu_req, cpu_we, vid_req, dma_req, dma_we;
    logic [15:0] cpu_addr, vid_addr, dma_addr, mem_addr;
    logic [7:0]  cpu_wdata, dma_wdata, cpu_rdata, vid_rdata, dma_rdata, mem_wdata, mem_rdata;
    logic        cpu_ack, vid_ack, dma_ack, mem_we;
    logic [1:0]  slot_idx;
`ifdef ARB_STATS_EN
    logic        stats_clr;
    logic [15:0] cpu_grants, vid_grants, dma_grants, idle_slots;
`endif

    int checks = 0;
    int failures = 0;
    logic chk_en = 1'b0;

    always #5 CLOCK_50 = ~CLOCK_50;

    mem_slot_arbiter #(.SLOT_LEN(L), .ADDR_W(16), .DATA_W(8)) dut (
        .CLOCK_50(CLOCK_50), .reset_n(reset_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_rdata(vid_rdata), .vid_ack(vid_ack),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_rdata(dma_rdata), .dma_ack(dma_ack),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
        .slot_idx(slot_idx)
`ifdef ARB_STATS_EN
        ,
        .stats_clr(stats_clr), .cpu_grants(cpu_grants), .vid_grants(vid_grants),
        .dma_grants(dma_grants), .idle_slots(idle_slots)
`endif
    );

    // Power-on RAM contents; 16'h8000 holds the video test pattern.
    function automatic logic [7:0] ram_init(input logic [15:0] a);
        return (a == 16'h8000) ? 8'h5A : (a[7:0] ^ 8'h3C);
    endfunction

    // Bench RAM: combinational read, write on edges where mem_we is high.
    bit [7:0] ram [65536];
    bit       ram_wr [65536];
    assign mem_rdata = ram_wr[mem_addr] ? ram[mem_addr] : ram_init(mem_addr);
    always @(posedge CLOCK_50) begin
        if (mem_we) begin
            ram[mem_addr]    <= mem_wdata;
            ram_wr[mem_addr] <= 1'b1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // m_cyc counts clocks since reset release (-1 = reset state); slot = m_cyc/L, position = m_cyc%L.
    int          m_cyc;
    int          m_owner;
    logic        m_we;
    logic [15:0] m_addr;
    logic [7:0]  m_wdata, m_cpu_rd, m_vid_rd, m_dma_rd;
    bit [7:0]    m_ram [65536];
    bit          m_wr [65536];
`ifdef ARB_STATS_EN
    int          m_cg, m_vg, m_dg, m_ig;
`endif

    function automatic int pick(input int slot, input logic c, input logic v, input logic d);
        if (slot % 2 == 0) return c ? OWN_CPU : (d ? OWN_DMA : OWN_NONE);
        return v ? OWN_VID : (d ? OWN_DMA : OWN_NONE);
    endfunction

    function automatic logic [7:0] model_rd(input logic [15:0] a);
        return m_wr[a] ? m_ram[a] : ram_init(a);
    endfunction

    function automatic int sat(input int v);
        return (v >= 65535) ? 65535 : v + 1;
    endfunction

    always @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            m_cyc <= -1; m_owner <= OWN_NONE; m_we <= 1'b0; m_addr <= '0; m_wdata <= '0;
            m_cpu_rd <= '0; m_vid_rd <= '0; m_dma_rd <= '0;
`ifdef ARB_STATS_EN
            m_cg <= 0; m_vg <= 0; m_dg <= 0; m_ig <= 0;
`endif
        end else begin
            m_cyc <= m_cyc + 1;
            if ((m_cyc + 1) % L == 0) begin
                case (pick((m_cyc + 1) / L, cpu_req, vid_req, dma_req))
                    OWN_CPU: begin m_owner <= OWN_CPU; m_we <= cpu_we; m_addr <= cpu_addr; m_wdata <= cpu_wdata; end
                    OWN_VID: begin m_owner <= OWN_VID; m_we <= 1'b0; m_addr <= vid_addr; end
                    OWN_DMA: begin m_owner <= OWN_DMA; m_we <= dma_we; m_addr <= dma_addr; m_wdata <= dma_wdata; end
                    default: begin m_owner <= OWN_NONE; m_we <= 1'b0; end
                endcase
            end
            if ((m_cyc + 1) % L == L - 2 && m_owner != OWN_NONE && m_we) begin
                m_ram[m_addr] <= m_wdata;
                m_wr[m_addr]  <= 1'b1;
            end
            if ((m_cyc + 1) % L == L - 1 && m_owner != OWN_NONE && !m_we) begin
                case (m_owner)
                    OWN_CPU: m_cpu_rd <= model_rd(m_addr);
                    OWN_VID: m_vid_rd <= model_rd(m_addr);
                    default: m_dma_rd <= model_rd(m_addr);
                endcase
            end
`ifdef ARB_STATS_EN
            if (stats_clr) begin
                m_cg <= 0; m_vg <= 0; m_dg <= 0; m_ig <= 0;
            end else if ((m_cyc + 1) % L == 0) begin
                case (pick((m_cyc + 1) / L, cpu_req, vid_req, dma_req))
                    OWN_CPU: m_cg <= sat(m_cg);
                    OWN_VID: m_vg <= sat(m_vg);
                    OWN_DMA: m_dg <= sat(m_dg);
                    default: m_ig <= sat(m_ig);
                endcase
            end
`endif
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge CLOCK_50) begin
        if (chk_en) begin
            check("slot_idx", 32'(slot_idx), (m_cyc < 0) ? 32'd3 : 32'((m_cyc / L) % 4));
            check("mem_addr", 32'(mem_addr), 32'(m_addr));
            check("mem_we", 32'(mem_we),
                  32'(m_owner != OWN_NONE && m_we && (m_cyc % L) >= 1 && (m_cyc % L) <= L - 3));
            if (m_cyc < 0 || (m_owner != OWN_NONE && m_we))
                check("mem_wdata", 32'(mem_wdata), 32'(m_wdata));
            check("cpu_ack", 32'(cpu_ack), 32'(m_owner == OWN_CPU && (m_cyc % L) == L - 1));
            check("vid_ack", 32'(vid_ack), 32'(m_owner == OWN_VID && (m_cyc % L) == L - 1));
            check("dma_ack", 32'(dma_ack), 32'(m_owner == OWN_DMA && (m_cyc % L) == L - 1));
            check("cpu_rdata", 32'(cpu_rdata), 32'(m_cpu_rd));
            check("vid_rdata", 32'(vid_rdata), 32'(m_vid_rd));
            check("dma_rdata", 32'(dma_rdata), 32'(m_dma_rd));
`ifdef ARB_STATS_EN
            check("cpu_grants", 32'(cpu_grants), 32'(m_cg));
            check("vid_grants", 32'(vid_grants), 32'(m_vg));
            check("dma_grants", 32'(dma_grants), 32'(m_dg));
            check("idle_slots", 32'(idle_slots), 32'(m_ig));
`endif
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n = 1);
        repeat (n) @(posedge CLOCK_50);
        #2;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick(2);
        reset_n = 1'b1;
    endtask

    task automatic idle_inputs();
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        vid_req = 1'b0; vid_addr = '0;
        dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
`ifdef ARB_STATS_EN
        stats_clr = 1'b0;
`endif
    endtask

    initial begin
        idle_inputs();
        reset_n = 1'b1;
        #1;
        reset_n = 1'b0;
        chk_en  = 1'b1;
        #2;
        check("rst_slot_idx", 32'(slot_idx), 32'd3);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        tick(2);
        reset_n = 1'b1;

        // 1: idle slots step 0..3 every L clocks, nothing strobes.
        for (int k = 1; k <= 17; k++) begin
            tick();
            check("t1_slot_idx", 32'(slot_idx), 32'(((k - 1) / 4) % 4));
            check("t1_quiet", 32'({mem_we, cpu_ack, vid_ack, dma_ack}), 32'd0);
        end

        // 2: CPU write in slot 0; req dropped mid-slot still completes.
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h1234; cpu_wdata = 8'hA5;
        do_reset();
        tick();
        check("t2_addr_c0", 32'(mem_addr), 32'h1234);
        check("t2_wdata_c0", 32'(mem_wdata), 32'hA5);
        check("t2_we_c0", 32'(mem_we), 32'd0);
        tick();
        check("t2_we_c1", 32'(mem_we), 32'd1);
        cpu_req = 1'b0;
        tick();
        check("t2_we_c2", 32'(mem_we), 32'd0);
        check("t2_ack_c2", 32'(cpu_ack), 32'd0);
        tick();
        check("t2_ack_c3", 32'(cpu_ack), 32'd1);
        tick();
        check("t2_ack_after", 32'(cpu_ack), 32'd0);
        idle_inputs();

        // 3: video read of 16'h8000 in slot 1, re-granted in slot 3.
        vid_req = 1'b1; vid_addr = 16'h8000;
        do_reset();
        tick(4);
        check("t3_noack_s0", 32'(vid_ack), 32'd0);
        tick(4);
        check("t3_ack_s1", 32'(vid_ack), 32'd1);
        check("t3_rdata_s1", 32'(vid_rdata), 32'h5A);
        tick();
        check("t3_ack_drop", 32'(vid_ack), 32'd0);
        check("t3_rdata_held", 32'(vid_rdata), 32'h5A);
        tick(4);
        check("t3_slot3", 32'(slot_idx), 32'd3);
        check("t3_addr_s3", 32'(mem_addr), 32'h8000);
        tick(3);
        check("t3_ack_s3", 32'(vid_ack), 32'd1);
        idle_inputs();

        // 4: full load alternates CPU/VID, DMA starves; then DMA takes even slots.
        cpu_req = 1'b1; cpu_addr = 16'h0003;
        vid_req = 1'b1; vid_addr = 16'h0005;
        dma_req = 1'b1; dma_addr = 16'h0007;
        do_reset();
        for (int s = 0; s < 8; s++) begin
            tick(4);
            check("t4_cpu_ack", 32'(cpu_ack), 32'(s % 2 == 0));
            check("t4_vid_ack", 32'(vid_ack), 32'(s % 2 == 1));
            check("t4_dma_starve", 32'(dma_ack), 32'd0);
        end
        cpu_req = 1'b0;
        for (int s = 8; s < 12; s++) begin
            tick(4);
            check("t4_dma_ack", 32'(dma_ack), 32'(s % 2 == 0));
            check("t4_vid_ack2", 32'(vid_ack), 32'(s % 2 == 1));
            check("t4_cpu_none", 32'(cpu_ack), 32'd0);
        end
        check("t4_dma_rdata", 32'(dma_rdata), 32'(8'h07 ^ 8'h3C));
        idle_inputs();

        // 5: reset during ACCESS of a CPU write abandons it; held req re-granted.
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0042; cpu_wdata = 8'h77;
        do_reset();
        tick(2);
        check("t5_we_c1", 32'(mem_we), 32'd1);
        reset_n = 1'b0;
        #1;
        check("t5_we_drop", 32'(mem_we), 32'd0);
        check("t5_slot_rst", 32'(slot_idx), 32'd3);
        tick(2);
        check("t5_no_ack", 32'(cpu_ack), 32'd0);
        reset_n = 1'b1;
        tick();
        check("t5_regrant_addr", 32'(mem_addr), 32'h0042);
        tick();
        check("t5_regrant_we", 32'(mem_we), 32'd1);
        tick(2);
        check("t5_regrant_ack", 32'(cpu_ack), 32'd1);
        idle_inputs();

`ifdef ARB_STATS_EN
        // 6: eight slots with video only, then a clear coinciding with a slot entry.
        vid_req = 1'b1;
        do_reset();
        tick(32);
        check("t6_vid_grants", 32'(vid_grants), 32'd4);
        check("t6_idle_slots", 32'(idle_slots), 32'd4);
        check("t6_cpu_grants", 32'(cpu_grants), 32'd0);
        stats_clr = 1'b1;
        tick();
        stats_clr = 1'b0;
        check("t6_clr", 32'({cpu_grants, vid_grants} | {dma_grants, idle_slots}), 32'd0);
        idle_inputs();
`endif

        // Randomized traffic with one mid-run reset; the compare process checks every cycle.
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            if (i == 1000) do_reset();
            tick();
            cpu_req   = ($urandom_range(0, 3) != 0);
            cpu_we    = $urandom_range(0, 1) == 1;
            cpu_addr  = 16'($urandom_range(0, 31));
            cpu_wdata = 8'($urandom);
            vid_req   = ($urandom_range(0, 2) == 0);
            vid_addr  = 16'($urandom_range(0, 31));
            dma_req   = ($urandom_range(0, 1) == 1);
            dma_we    = $urandom_range(0, 1) == 1;
            dma_addr  = 16'($urandom_range(0, 31));
            dma_wdata = 8'($urandom);
`ifdef ARB_STATS_EN
            stats_clr = ($urandom_range(0, 63) == 0);
`endif
        end
        idle_inputs();
        tick(8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
